// File: rtl/ex_pkg.sv
// Shared types and constants for the execute stage: ALU op codes, iterative FSM states,
// flag bit positions and default widths.
package ex_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int RA_W_DEF  = 4;

  // Bit positions inside the 4-bit {N,Z,C,V} flag vector.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_ORR = 3'b011,
    OP_MUL = 3'b100,
    OP_MOD = 3'b101,
    OP_MOV = 3'b110,
    OP_XOR = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } ex_state_e;

  function automatic logic is_iter_op(logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/ex_muldiv_iter.sv
// Iterative 32-step unit: shift-add multiply (low half of product) and restoring unsigned modulo.
// IDLE -> BUSY for WIDTH iterations -> DONE for one cycle; flush abandons the operation.
module ex_muldiv_iter
  import ex_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             flush,
  input  alu_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             divzero
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  ex_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             is_mod_q;
  logic [WIDTH-1:0] opa_q, opb_q, acc_q, acc_step;
  logic [WIDTH:0]   rem_shift;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_BUSY;
      ST_BUSY: begin
        if (flush)                  state_d = ST_IDLE;
        else if (cnt_q == CNT_LAST) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Modulo brings the next dividend bit into the partial remainder; multiply adds the shifted
  // multiplicand.
  always_comb begin
    rem_shift = {acc_q, opa_q[WIDTH-1]};
    if (is_mod_q) begin
      if (rem_shift >= {1'b0, opb_q}) acc_step = WIDTH'(rem_shift - {1'b0, opb_q});
      else                            acc_step = rem_shift[WIDTH-1:0];
    end else begin
      acc_step = acc_q + (opb_q[0] ? opa_q : '0);
    end
  end

  // NOTE: every flop, datapath included, takes the async reset so a reset mid-operation
  // leaves no stale partial result behind.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      is_mod_q <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && start) begin
        cnt_q    <= '0;
        is_mod_q <= (op == OP_MOD);
        opa_q    <= a;
        opb_q    <= b;
        acc_q    <= '0;
      end else if (state_q == ST_BUSY) begin
        cnt_q <= cnt_q + 1'b1;
        acc_q <= acc_step;
        opa_q <= opa_q << 1;
        if (!is_mod_q) opb_q <= opb_q >> 1;
      end
    end
  end

  assign busy    = (state_q == ST_BUSY);
  assign done    = (state_q == ST_DONE);
  assign result  = acc_q;
  assign divzero = is_mod_q && (opb_q == '0);

endmodule

// File: rtl/ex_stage_muldiv.sv
// Execute stage: operand select, single-cycle ALU and the registered EX/MEM bundle (falling edge).
// Define EX_MULDIV_EN to build the iterative MUL/MOD unit and its stall; otherwise MUL/MOD return 0.
module ex_stage_muldiv
  import ex_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int RA_W  = RA_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             RegWriteE,
  input  logic             MemtoRegE,
  input  logic             MemWriteE,
  input  logic             BranchE,
  input  logic             ALUSrcE,
  input  logic [2:0]       ALUControlE,
  input  logic [RA_W-1:0]  WA3E,
  input  logic [WIDTH-1:0] rd1E,
  input  logic [WIDTH-1:0] rd2E,
  input  logic [WIDTH-1:0] ExtImmE,
  input  logic             flush_e,
  output logic             stall_o,
  output logic             RegWriteM,
  output logic             MemtoRegM,
  output logic             MemWriteM,
  output logic             BranchM,
  output logic [RA_W-1:0]  WA3M,
  output logic [WIDTH-1:0] ALUResultM,
  output logic [WIDTH-1:0] WriteDataM,
  output logic [3:0]       FlagsM
);

  logic [WIDTH-1:0] src_b, alu_res, iter_res, result_d, wdata_d;
  logic [WIDTH:0]   sum_ext, diff_ext;
  logic             alu_c, alu_v, iter_v, take_alu, take_iter;
  logic             regwrite_d, memtoreg_d, memwrite_d, branch_d;
  logic [RA_W-1:0]  wa3_d;
  logic [3:0]       flags_d;

  assign src_b    = ALUSrcE ? ExtImmE : rd2E;
  assign sum_ext  = {1'b0, rd1E} + {1'b0, src_b};
  assign diff_ext = {1'b0, rd1E} - {1'b0, src_b};

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (ALUControlE)
      OP_ADD: begin
        alu_res = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
        alu_v   = (rd1E[WIDTH-1] == src_b[WIDTH-1]) && (alu_res[WIDTH-1] != rd1E[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff_ext[WIDTH-1:0];
        alu_c   = ~diff_ext[WIDTH];  // carry means no borrow
        alu_v   = (rd1E[WIDTH-1] != src_b[WIDTH-1]) && (alu_res[WIDTH-1] != rd1E[WIDTH-1]);
      end
      OP_AND:  alu_res = rd1E & src_b;
      OP_ORR:  alu_res = rd1E | src_b;
      OP_MOV:  alu_res = src_b;
      OP_XOR:  alu_res = rd1E ^ src_b;
      default: ;  // MUL/MOD: result comes from the iterative unit, or is 0 without it
    endcase
  end

`ifdef EX_MULDIV_EN
  logic             it_start, it_busy, it_done, it_divzero;
  logic [WIDTH-1:0] it_result;

  assign it_start = is_iter_op(ALUControlE) && !flush_e && !it_busy && !it_done;
  assign stall_o  = rst_n && !flush_e && (it_start || it_busy);

  ex_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (it_start),
    .flush   (flush_e),
    .op      (alu_op_e'(ALUControlE)),
    .a       (rd1E),
    .b       (src_b),
    .busy    (it_busy),
    .done    (it_done),
    .result  (it_result),
    .divzero (it_divzero)
  );

  // The held instruction's control rides along with the result in the DONE cycle.
  assign take_iter = it_done && !flush_e;
  assign take_alu  = !flush_e && !it_start && !it_busy && !it_done;
  assign iter_res  = it_result;
  assign iter_v    = it_divzero;
`else
  assign stall_o   = 1'b0;
  assign take_iter = 1'b0;
  assign take_alu  = !flush_e;
  assign iter_res  = '0;
  assign iter_v    = 1'b0;
`endif

  always_comb begin
    regwrite_d = 1'b0;
    memtoreg_d = 1'b0;
    memwrite_d = 1'b0;
    branch_d   = 1'b0;
    wa3_d      = '0;
    result_d   = '0;
    wdata_d    = '0;
    flags_d    = '0;
    if (take_alu || take_iter) begin
      regwrite_d      = RegWriteE;
      memtoreg_d      = MemtoRegE;
      memwrite_d      = MemWriteE;
      branch_d        = BranchE;
      wa3_d           = WA3E;
      wdata_d         = rd2E;
      result_d        = take_iter ? iter_res : alu_res;
      flags_d[FLAG_N] = result_d[WIDTH-1];
      flags_d[FLAG_Z] = (result_d == '0);
      flags_d[FLAG_C] = take_iter ? 1'b0 : alu_c;
      flags_d[FLAG_V] = take_iter ? iter_v : alu_v;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWriteM  <= 1'b0;
      MemtoRegM  <= 1'b0;
      MemWriteM  <= 1'b0;
      BranchM    <= 1'b0;
      WA3M       <= '0;
      ALUResultM <= '0;
      WriteDataM <= '0;
      FlagsM     <= '0;
    end else begin
      RegWriteM  <= regwrite_d;
      MemtoRegM  <= memtoreg_d;
      MemWriteM  <= memwrite_d;
      BranchM    <= branch_d;
      WA3M       <= wa3_d;
      ALUResultM <= result_d;
      WriteDataM <= wdata_d;
      FlagsM     <= flags_d;
    end
  end

endmodule

// File: tb/tb_ex_stage_muldiv.sv
// Self-checking bench for ex_stage_muldiv: directed table, multi-cycle sequences and random
// stimulus against an arithmetic reference model. Follows the EX_MULDIV_EN build of the RTL.
module tb_ex_stage_muldiv;
  import ex_pkg::*;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic        alusrc;
    logic        regw;
    logic        memtoreg;
    logic        memw;
    logic        branch;
    logic [3:0]  wa3;
  } in_t;

  typedef struct packed {
    in_t         stim;
    logic [31:0] res;
    logic [3:0]  fl;
  } vec_t;

  // {RegWrite, MemtoReg, MemWrite, Branch, WA3, ALUResult, WriteData, Flags}
  typedef logic [75:0] bundle_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE, flush_e;
  logic [2:0]  ALUControlE;
  logic [3:0]  WA3E;
  logic [31:0] rd1E, rd2E, ExtImmE;
  logic        stall_o, RegWriteM, MemtoRegM, MemWriteM, BranchM;
  logic [3:0]  WA3M, FlagsM;
  logic [31:0] ALUResultM, WriteDataM;

  int   n_cmp  = 0;
  int   n_fail = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  ex_stage_muldiv dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .RegWriteE   (RegWriteE),
    .MemtoRegE   (MemtoRegE),
    .MemWriteE   (MemWriteE),
    .BranchE     (BranchE),
    .ALUSrcE     (ALUSrcE),
    .ALUControlE (ALUControlE),
    .WA3E        (WA3E),
    .rd1E        (rd1E),
    .rd2E        (rd2E),
    .ExtImmE     (ExtImmE),
    .flush_e     (flush_e),
    .stall_o     (stall_o),
    .RegWriteM   (RegWriteM),
    .MemtoRegM   (MemtoRegM),
    .MemWriteM   (MemWriteM),
    .BranchM     (BranchM),
    .WA3M        (WA3M),
    .ALUResultM  (ALUResultM),
    .WriteDataM  (WriteDataM),
    .FlagsM      (FlagsM)
  );

  function automatic in_t mk(logic [2:0] op, logic [31:0] a, logic [31:0] b, logic [31:0] imm,
                             logic alusrc, logic [3:0] ctrl, logic [3:0] wa3);
    in_t v;
    v.op = op;  v.a = a;  v.b = b;  v.imm = imm;  v.alusrc = alusrc;
    {v.regw, v.memtoreg, v.memw, v.branch} = ctrl;
    v.wa3 = wa3;
    return v;
  endfunction

  function automatic bundle_t exp_of(in_t v, logic [31:0] res, logic [3:0] fl);
    return {v.regw, v.memtoreg, v.memw, v.branch, v.wa3, res, v.b, fl};
  endfunction

  // Reference model: plain integer arithmetic on the operation definitions.
  function automatic bundle_t model(in_t v);
    logic [31:0]     sb, res;
    logic            c, ov;
    longint          sa, ss, r;
    longint unsigned ua, ub;
    sb = v.alusrc ? v.imm : v.b;
    res = '0;  c = 1'b0;  ov = 1'b0;
    sa = $signed(v.a);  ss = $signed(sb);  ua = v.a;  ub = sb;
    case (v.op)
      3'd0: begin
        res = v.a + sb;  c = ((ua + ub) >> 32) != 0;
        r = sa + ss;     ov = (r != longint'($signed(res)));
      end
      3'd1: begin
        res = v.a - sb;  c = (ua >= ub);
        r = sa - ss;     ov = (r != longint'($signed(res)));
      end
      3'd2: res = v.a & sb;
      3'd3: res = v.a | sb;
`ifdef EX_MULDIV_EN
      3'd4: res = v.a * sb;
      3'd5: begin
        if (sb == 0) begin res = v.a;  ov = 1'b1; end
        else         res = v.a % sb;
      end
`endif
      3'd6: res = sb;
      3'd7: res = v.a ^ sb;
      default: ;
    endcase
    return exp_of(v, res, {res[31], res == 0, c, ov});
  endfunction

  function automatic bundle_t get_bundle();
    return {RegWriteM, MemtoRegM, MemWriteM, BranchM, WA3M, ALUResultM, WriteDataM, FlagsM};
  endfunction

  task automatic check(input string name, input bundle_t act, input bundle_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic apply(input in_t v);
    ALUControlE = v.op;  rd1E = v.a;  rd2E = v.b;  ExtImmE = v.imm;  ALUSrcE = v.alusrc;
    RegWriteE = v.regw;  MemtoRegE = v.memtoreg;  MemWriteE = v.memw;  BranchE = v.branch;
    WA3E = v.wa3;  flush_e = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic add_vec(input in_t v, input logic [31:0] res, input logic [3:0] fl);
    vec_t t;
    t.stim = v;  t.res = res;  t.fl = fl;
    tbl.push_back(t);
  endtask

  // Iterative op: stall for 33 cycles, bubbles for 33 edges, result on edge 34.
  task automatic run_iter(input string name, input in_t v, input bundle_t exp);
    int   stalls = 0;
    logic bub_ok = 1'b1;
    apply(v);
    for (int e = 1; e <= 34; e++) begin
      #1;
      if (stall_o) stalls++;
      tick();
      if (e < 34 && get_bundle() != '0) bub_ok = 1'b0;
    end
    check({name, " stall cycles"}, bundle_t'(stalls), bundle_t'(33));
    check({name, " bubbles"}, bundle_t'(bub_ok), bundle_t'(1));
    check({name, " result"}, get_bundle(), exp);
  endtask

  task automatic rand_vec(input logic iter, output in_t v);
    logic [2:0] op;
    if (iter) op = 3'($urandom_range(4, 5));
    else begin
`ifdef EX_MULDIV_EN
      op = 3'($urandom_range(0, 5));
      if (op >= 3'd4) op = op + 3'd2;
`else
      op = 3'($urandom_range(0, 7));
`endif
    end
    v = mk(op, $urandom, $urandom, $urandom, 1'($urandom), 4'($urandom), 4'($urandom));
    case ($urandom_range(0, 4))
      0: begin v.b = '0;  v.imm = '0; end
      1: begin v.b = v.a; v.imm = v.a; end
      2: begin v.b = 32'($urandom_range(0, 15)); v.imm = v.b; end
      default: ;
    endcase
  endtask

  initial begin
    in_t v;

    // Reset state
    rst_n = 1'b0;
    apply(mk(OP_ADD, 0, 0, 0, 0, 4'b0000, 0));
    #2;
    check("reset bundle", get_bundle(), '0);
    check("reset stall", bundle_t'(stall_o), '0);
    rst_n = 1'b1;
    tick();

    // Directed single-cycle table
    add_vec(mk(OP_ADD, 32'h7FFF_FFFF, 1, 0, 0, 4'b1000, 1), 32'h8000_0000, 4'b1001);
    add_vec(mk(OP_SUB, 5, 5, 0, 0, 4'b1000, 2), 32'h0, 4'b0110);
    add_vec(mk(OP_ADD, 32'hFFFF_FFFF, 1, 0, 0, 4'b0001, 3), 32'h0, 4'b0110);
    add_vec(mk(OP_SUB, 1, 2, 0, 0, 4'b1100, 4), 32'hFFFF_FFFF, 4'b1000);
    add_vec(mk(OP_SUB, 32'h8000_0000, 1, 0, 0, 4'b1000, 5), 32'h7FFF_FFFF, 4'b0011);
    add_vec(mk(OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 0, 4'b1000, 6), 32'hF000_F000, 4'b1000);
    add_vec(mk(OP_ORR, 32'h0000_0F00, 32'hDEAD_BEEF, 32'h0000_00F0, 1, 4'b0010, 7), 32'h0000_0FF0, 4'b0000);
    add_vec(mk(OP_MOV, 0, 5, 0, 1, 4'b1000, 8), 32'h0, 4'b0100);
    add_vec(mk(OP_XOR, 32'hAAAA_5555, 32'hAAAA_5555, 0, 0, 4'b1000, 9), 32'h0, 4'b0100);
    add_vec(mk(OP_MOV, 0, 32'h8000_0000, 0, 0, 4'b1000, 10), 32'h8000_0000, 4'b1000);
`ifndef EX_MULDIV_EN
    add_vec(mk(OP_MUL, 7, 0, 6, 1, 4'b1000, 11), 32'h0, 4'b0100);
    add_vec(mk(OP_MOD, 100, 7, 0, 0, 4'b1000, 12), 32'h0, 4'b0100);
`endif
    foreach (tbl[i]) begin
      apply(tbl[i].stim);
      tick();
      check($sformatf("table %0d", i), get_bundle(), exp_of(tbl[i].stim, tbl[i].res, tbl[i].fl));
    end

    // Flush of a single-cycle op
    apply(mk(OP_ADD, 5, 5, 0, 0, 4'b1000, 1));
    flush_e = 1'b1;
    tick();
    check("flush single", get_bundle(), '0);

    // Async reset while a result is held in EX/MEM
    apply(mk(OP_ADD, 32'h7FFF_FFFF, 1, 0, 0, 4'b1000, 5));
    tick();
`ifdef EX_MULDIV_EN
    apply(mk(OP_MUL, 7, 0, 6, 1, 4'b1000, 2));
    #1;
    check("stall on arrival", bundle_t'(stall_o), bundle_t'(1));
`endif
    rst_n = 1'b0;
    #1;
    check("async reset bundle", get_bundle(), '0);
    check("async reset stall", bundle_t'(stall_o), '0);
    apply(mk(OP_ADD, 0, 0, 0, 0, 4'b0000, 0));
    #1;
    rst_n = 1'b1;
    tick();

`ifdef EX_MULDIV_EN
    // Directed iterative ops
    v = mk(OP_MUL, 7, 32'h1234, 6, 1, 4'b1000, 2);
    run_iter("mul 7*6", v, exp_of(v, 42, 4'b0000));
    v = mk(OP_MOD, 100, 7, 0, 0, 4'b1000, 3);
    run_iter("mod 100%7", v, exp_of(v, 2, 4'b0000));
    v = mk(OP_MOD, 100, 0, 0, 0, 4'b1000, 4);
    run_iter("mod 100%0", v, exp_of(v, 100, 4'b0001));

    // Flush in BUSY cycle 10
    apply(mk(OP_MUL, 7, 0, 6, 1, 4'b1000, 2));
    repeat (10) tick();
    flush_e = 1'b1;
    #1;
    check("flush busy stall", bundle_t'(stall_o), '0);
    tick();
    check("flush busy bubble", get_bundle(), '0);
    v = mk(OP_ADD, 1, 2, 0, 0, 4'b1000, 3);
    apply(v);
    #1;
    check("post flush stall", bundle_t'(stall_o), '0);
    tick();
    check("post flush add", get_bundle(), exp_of(v, 3, 4'b0000));

    // Back-to-back iterative ops, then a plain op must not see a repeated MOD
    v = mk(OP_MUL, 3, 3, 0, 0, 4'b1000, 5);
    run_iter("b2b mul", v, exp_of(v, 9, 4'b0000));
    v = mk(OP_MOD, 10, 4, 0, 0, 4'b1000, 6);
    run_iter("b2b mod", v, exp_of(v, 2, 4'b0000));
    v = mk(OP_ADD, 1, 1, 0, 0, 4'b1000, 7);
    apply(v);
    tick();
    check("b2b follow add", get_bundle(), exp_of(v, 2, 4'b0000));

    // Reset mid-BUSY aborts cleanly; the next op runs from scratch
    apply(mk(OP_MUL, 7, 0, 6, 1, 4'b1000, 2));
    repeat (5) tick();
    check("busy stall", bundle_t'(stall_o), bundle_t'(1));
    rst_n = 1'b0;
    #1;
    check("busy reset stall", bundle_t'(stall_o), '0);
    check("busy reset bundle", get_bundle(), '0);
    apply(mk(OP_ADD, 0, 0, 0, 0, 4'b0000, 0));
    #1;
    rst_n = 1'b1;
    #1;
    v = mk(OP_MUL, 7, 0, 6, 1, 4'b1000, 2);
    run_iter("mul after reset", v, exp_of(v, 42, 4'b0000));

    // Random iterative ops against the model
    for (int i = 0; i < 8; i++) begin
      rand_vec(1'b1, v);
      run_iter($sformatf("rand iter %0d op %0d", i, v.op), v, model(v));
    end
`endif

    // Random single-cycle ops against the model
    for (int i = 0; i < 200; i++) begin
      rand_vec(1'b0, v);
      apply(v);
      tick();
      check($sformatf("rand single %0d op %0d", i, v.op), get_bundle(), model(v));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
